cfg_hs_master: RTL and testbench

CFG_HS_MASTER -- requirements
Module: cfg_hs_master

---
 rtl/pkg_common.sv | 20 ++
 rtl/cfg_sync.sv | 25 ++
 rtl/cfg_hs_master.sv | 156 +++++++++++++++
 tb/tb_cfg_hs_master.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_common.sv
// pkg_common: shared types and constants for the config-bus blocks.
package pkg_common;

  localparam int WORD_W     = 32;
  localparam int CFG_ADDR_W = 16;
  localparam int TMO_W      = 16;

  typedef logic [WORD_W-1:0]     word_t;
  typedef logic [CFG_ADDR_W-1:0] cfg_addr_t;
  typedef logic [TMO_W-1:0]      tmo_cnt_t;

  // Read data returned when a config transfer is aborted by timeout.
  localparam word_t CFG_ERR_RDATA = 32'hDEAD_BEEF;

  // Increment that sticks at all-ones instead of wrapping to zero.
  function automatic tmo_cnt_t sat_inc(input tmo_cnt_t v);
    return (v == '1) ? v : v + tmo_cnt_t'(1);
  endfunction

endpackage

// File: rtl/cfg_sync.sv
// cfg_sync: multi-flop synchronizer for a single-bit asynchronous level.
module cfg_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] r_sync;

  // Shift the asynchronous level through the flop chain; cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync <= '0;
    end else begin
      // NOTE: non-blocking so each stage captures the previous stage's old value.
      r_sync <= {r_sync[STAGES-2:0], d_i};
    end
  end

  assign q_o = r_sync[STAGES-1];

endmodule

// File: rtl/cfg_hs_master.sv
// cfg_hs_master: SoC-side master for a 4-phase request/acknowledge config
// handshake into an asynchronous accelerator domain. One transfer in flight.
module cfg_hs_master
  import pkg_common::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      req_i,
  output logic      gnt_o,
  input  logic      we_i,
  input  cfg_addr_t addr_i,
  input  word_t     wdata_i,
  output logic      rvalid_o,
  output word_t     rdata_o,
  output logic      err_o,
  output logic      cfg_req_o,
  output cfg_addr_t cfg_ad_o,
  output logic      cfg_web_o,
  output word_t     cfg_d_o,
  input  word_t     cfg_q_i,
  input  logic      cfg_ack_i
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_REQ     = 3'd2;
  localparam logic [2:0] ST_RELEASE = 3'd3;
  localparam logic [2:0] ST_RESP    = 3'd4;

  localparam tmo_cnt_t   TMO_LAST    = tmo_cnt_t'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0] SETTLE_INIT = 3'(SYNC_STAGES);

  logic [2:0] r_state;
  tmo_cnt_t   r_cnt;
  logic [2:0] r_settle;
  logic       r_cfg_req;
  logic       r_web;
  logic       r_err;
  cfg_addr_t  r_ad;
  word_t      r_d;
  word_t      r_rdata;

  logic       w_ack_sync;
  logic       w_gnt;
  logic       w_rvalid;

  cfg_sync #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (cfg_ack_i),
    .q_o   (w_ack_sync)
  );

  // After reset the synchronizer reads 0 regardless of the real ack level;
  // block grants until the chain has been refilled from cfg_ack_i so a stale
  // acknowledge is seen and allowed to return to zero first.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_settle <= SETTLE_INIT;
    end else if (r_settle != '0) begin
      r_settle <= r_settle - 3'd1;
    end
  end

  // Grant and response strobes, both held low while reset is applied.
  always_comb begin
    // NOTE: defaults first so every path assigns every output (no latch).
    w_gnt    = 1'b0;
    w_rvalid = 1'b0;
    if (!rst_i) begin
      w_gnt    = (r_state == ST_IDLE) && req_i && !w_ack_sync && (r_settle == '0);
      w_rvalid = (r_state == ST_RESP);
    end
  end

  // Transfer FSM: capture, setup, request, release, respond.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_cfg_req <= 1'b0;
      r_web     <= 1'b1;
      r_ad      <= '0;
      r_d       <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt) begin
            r_ad    <= addr_i;
            r_d     <= wdata_i;
            r_web   <= ~we_i;
            r_state <= ST_SETUP;
          end
        end

        // Address/data/web settle for a cycle before the request rises.
        ST_SETUP: begin
          r_cnt     <= '0;
          r_cfg_req <= 1'b1;
          r_state   <= ST_REQ;
        end

        // An ack seen in the final allowed cycle still wins over the timeout.
        // cfg_q_i is only sampled after the synchronized ack, by which point
        // the accelerator holds it stable.
        ST_REQ: begin
          r_cnt <= sat_inc(r_cnt);
          if (w_ack_sync) begin
            r_rdata   <= r_web ? cfg_q_i : '0;
            r_err     <= 1'b0;
            r_cfg_req <= 1'b0;
            r_state   <= ST_RELEASE;
          end else if (r_cnt == TMO_LAST) begin
            r_rdata   <= CFG_ERR_RDATA;
            r_err     <= 1'b1;
            r_cfg_req <= 1'b0;
            r_state   <= ST_RELEASE;
          end
        end

        // Wait for the acknowledge to return to zero before responding.
        ST_RELEASE: begin
          if (!w_ack_sync) begin
            r_state <= ST_RESP;
          end
        end

        ST_RESP: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state   <= ST_IDLE;
          r_cfg_req <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_o     = w_gnt;
  assign rvalid_o  = w_rvalid;
  assign rdata_o   = w_rvalid ? r_rdata : '0;
  assign err_o     = w_rvalid & r_err;
  assign cfg_req_o = r_cfg_req;
  assign cfg_ad_o  = r_ad;
  assign cfg_web_o = r_web;
  assign cfg_d_o   = r_d;

endmodule

// File: tb/tb_cfg_hs_master.sv
// tb_cfg_hs_master: directed bench with an accelerator-side handshake model.
module tb_cfg_hs_master;
  import pkg_common::*;

  localparam int TB_SYNC = 2;
  localparam int TB_TMO  = 16;

  logic      clk_i = 1'b0;
  logic      rst_i = 1'b1;
  logic      req_i = 1'b0;
  logic      we_i  = 1'b0;
  cfg_addr_t addr_i = '0;
  word_t     wdata_i = '0;
  logic      gnt_o, rvalid_o, err_o, cfg_req_o, cfg_web_o;
  word_t     rdata_o, cfg_d_o;
  cfg_addr_t cfg_ad_o;
  word_t     cfg_q_i = '0;
  logic      cfg_ack_i = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  cfg_hs_master #(
    .SYNC_STAGES    (TB_SYNC),
    .TIMEOUT_CYCLES (TB_TMO)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_i),
    .gnt_o     (gnt_o),
    .we_i      (we_i),
    .addr_i    (addr_i),
    .wdata_i   (wdata_i),
    .rvalid_o  (rvalid_o),
    .rdata_o   (rdata_o),
    .err_o     (err_o),
    .cfg_req_o (cfg_req_o),
    .cfg_ad_o  (cfg_ad_o),
    .cfg_web_o (cfg_web_o),
    .cfg_d_o   (cfg_d_o),
    .cfg_q_i   (cfg_q_i),
    .cfg_ack_i (cfg_ack_i)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Accelerator model: raises ack ack_dly negedges after seeing cfg_req_o
  // (0 = never), drops it drop_dly cycles after cfg_req_o falls.
  int    ack_dly      = 3;
  int    drop_dly     = 0;
  int    seen         = 0;
  int    low_cnt      = 0;
  int    ack_fall_cyc = -1;
  word_t mem [int];

  always @(negedge clk_i) begin
    if (cfg_req_o) begin
      low_cnt = 0;
      if (!cfg_ack_i) begin
        seen = seen + 1;
        if (seen == ack_dly) begin
          cfg_ack_i = 1'b1;
          if (cfg_web_o) cfg_q_i = mem.exists(int'(cfg_ad_o)) ? mem[int'(cfg_ad_o)] : '0;
          else mem[int'(cfg_ad_o)] = cfg_d_o;
        end
      end
    end else begin
      seen = 0;
      if (cfg_ack_i) begin
        if (low_cnt >= drop_dly) begin
          cfg_ack_i    = 1'b0;
          ack_fall_cyc = cyc;
          low_cnt      = 0;
        end else begin
          low_cnt = low_cnt + 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic      we;
    cfg_addr_t addr;
    word_t     wdata;
    int        ack_dly;
    word_t     exp_rdata;
    logic      exp_err;
    int        exp_req_cyc;
  } vec_t;

  vec_t vecs [8];

  // One complete transfer from an idle DUT, checked cycle by cycle.
  task automatic do_txn(input string tag, input vec_t v);
    int    req_cyc  = 0;
    int    bad_web  = 0;
    int    bad_hold = 0;
    logic  got      = 1'b0;
    word_t rd       = '0;
    logic  er       = 1'b0;
    ack_dly = v.ack_dly;
    @(negedge clk_i);
    req_i = 1'b1; we_i = v.we; addr_i = v.addr; wdata_i = v.wdata;
    #1;
    check({tag, "_gnt"}, gnt_o, 1);
    @(negedge clk_i);
    req_i = 1'b0;
    #1;
    check({tag, "_setup_req_low"}, cfg_req_o, 0);
    for (int k = 0; k < 100 && !got; k++) begin
      if (k > 0) begin
        @(negedge clk_i);
        #1;
      end
      if (cfg_req_o) req_cyc++;
      if (cfg_web_o !== ~v.we) bad_web++;
      if (cfg_ad_o !== v.addr || cfg_d_o !== v.wdata) bad_hold++;
      if (rvalid_o) begin
        got = 1'b1;
        rd  = rdata_o;
        er  = err_o;
      end
    end
    check({tag, "_rvalid_seen"}, got, 1);
    check({tag, "_web_steady"}, bad_web, 0);
    check({tag, "_ad_d_hold"}, bad_hold, 0);
    check({tag, "_req_cycles"}, req_cyc, v.exp_req_cyc);
    check({tag, "_rdata"}, rd, v.exp_rdata);
    check({tag, "_err"}, er, v.exp_err);
    @(negedge clk_i);
    #1;
    check({tag, "_rvalid_single"}, rvalid_o, 0);
    check({tag, "_rdata_idle_zero"}, rdata_o, 0);
    check({tag, "_err_idle_zero"}, err_o, 0);
  endtask

  cfg_addr_t b_addr [3];
  word_t     b_exp  [3];

  initial begin
    int    n_g, n_rv, gnt_cyc;
    logic  outstanding, upd, got;

    vecs[0] = '{1'b1, 16'h1004, 32'hA5A5_5A5A, 3,  32'h0000_0000, 1'b0, 5};
    vecs[1] = '{1'b0, 16'h2000, 32'h0000_0000, 3,  32'h1234_5678, 1'b0, 5};
    vecs[2] = '{1'b0, 16'h1004, 32'h1111_2222, 3,  32'hA5A5_5A5A, 1'b0, 5};
    vecs[3] = '{1'b0, 16'h2000, 32'h0000_0000, 0,  32'hDEAD_BEEF, 1'b1, 16};
    vecs[4] = '{1'b0, 16'h2000, 32'h0000_0000, 14, 32'h1234_5678, 1'b0, 16};
    vecs[5] = '{1'b0, 16'h2000, 32'h0000_0000, 15, 32'hDEAD_BEEF, 1'b1, 16};
    vecs[6] = '{1'b1, 16'h1008, 32'h0BAD_0BAD, 0,  32'hDEAD_BEEF, 1'b1, 16};
    vecs[7] = '{1'b1, 16'h3000, 32'hCAFE_F00D, 1,  32'h0000_0000, 1'b0, 3};
    mem[32'h2000] = 32'h1234_5678;

    // Reset state, with a request pending to prove the grant is masked.
    req_i = 1'b1;
    repeat (3) @(negedge clk_i);
    #1;
    check("rst_gnt", gnt_o, 0);
    check("rst_rvalid", rvalid_o, 0);
    check("rst_cfg_req", cfg_req_o, 0);
    check("rst_cfg_web", cfg_web_o, 1);
    check("rst_cfg_ad", cfg_ad_o, 0);
    check("rst_cfg_d", cfg_d_o, 0);
    check("rst_rdata_err", {rdata_o, err_o}, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    req_i = 1'b0;
    repeat (3) @(negedge clk_i);

    for (int i = 0; i < 8; i++) do_txn($sformatf("v%0d", i), vecs[i]);

    // Back-to-back reads with req_i held high throughout.
    b_addr[0] = 16'h2000; b_exp[0] = 32'h1234_5678;
    b_addr[1] = 16'h1004; b_exp[1] = 32'hA5A5_5A5A;
    b_addr[2] = 16'h3000; b_exp[2] = 32'hCAFE_F00D;
    ack_dly = 3;
    n_g = 0; n_rv = 0; outstanding = 1'b0; upd = 1'b0;
    @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b0; addr_i = b_addr[0];
    for (int k = 0; k < 80; k++) begin
      #1;
      if (rvalid_o) begin
        if (n_rv < 3) check($sformatf("b2b_rdata%0d", n_rv), rdata_o, b_exp[n_rv]);
        n_rv++;
        outstanding = 1'b0;
      end
      if (gnt_o) begin
        check($sformatf("b2b_gnt%0d_after_rvalid", n_g), outstanding, 0);
        outstanding = 1'b1;
        n_g++;
        upd = 1'b1;
      end
      @(negedge clk_i);
      if (upd) begin
        upd = 1'b0;
        if (n_g < 3) addr_i = b_addr[n_g];
        else req_i = 1'b0;
      end
    end
    check("b2b_grant_count", n_g, 3);
    check("b2b_rvalid_count", n_rv, 3);

    // Reset while in Req with the ack already high and held for a while.
    ack_dly = 3; drop_dly = 5; got = 1'b0;
    @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b0; addr_i = 16'h2000;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk_i);
      req_i = 1'b0;
      #1;
      if (cfg_req_o && cfg_ack_i) got = 1'b1;
    end
    check("mrst_reached_req_ack", got, 1);
    rst_i = 1'b1;
    ack_fall_cyc = -1;
    @(posedge clk_i);
    #1;
    check("mrst_cfg_req_low", cfg_req_o, 0);
    check("mrst_cfg_web", cfg_web_o, 1);
    check("mrst_cfg_ad", cfg_ad_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    req_i = 1'b1; we_i = 1'b0; addr_i = 16'h1004;
    got = 1'b0; gnt_cyc = -1;
    for (int k = 0; k < 60 && !got; k++) begin
      if (k > 0) @(negedge clk_i);
      #1;
      if (gnt_o) begin
        got = 1'b1;
        gnt_cyc = cyc;
      end
    end
    check("mrst_granted", got, 1);
    check("mrst_gnt_after_sync", gnt_cyc, ack_fall_cyc + TB_SYNC);
    drop_dly = 0;
    @(negedge clk_i);
    req_i = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      #1;
      if (rvalid_o) begin
        got = 1'b1;
        check("mrst_rdata", rdata_o, 32'hA5A5_5A5A);
        check("mrst_err", err_o, 0);
      end
      @(negedge clk_i);
    end
    check("mrst_rvalid_seen", got, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
